// File: rtl/vdp1_cmd_fetch.sv
// rtl/vdp1_cmd_fetch.sv - VDP1 command-list walker: fetches 32-byte tables, follows JP, stops on END.
// Optional VDP1_CMD_MASK_EN: AND each fetched word with its field mask before storage.
module vdp1_cmd_fetch #(
  parameter int VRAM_AW   = 18,
  parameter int CMD_WORDS = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic [VRAM_AW:1]   VRAM_A,
  output logic               VRAM_RD,
  input  logic [15:0]        VRAM_DI,
  input  logic               VRAM_RDY,
  output logic [255:0]       CMD,
  output logic               CMD_VALID,
  input  logic               CMD_ACK,
  output logic               BUSY,
  output logic               CEF,
  output logic [15:0]        COPR,
  output logic [15:0]        LOPR
);

  localparam int TW = VRAM_AW - 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_RDN  = 3'd2;
  localparam logic [2:0] S_RD1  = 3'd3;
  localparam logic [2:0] S_DISP = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] table_q, table_d;
  logic [TW-1:0] stk_q, stk_d;
  logic          stk_v_q, stk_v_d;
  logic [3:0]    widx_q, widx_d;
  logic          rd_q, rd_d;
  logic          stale_q, stale_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          cef_q, cef_d;
  logic [255:0]  cmd_q, cmd_d;
  logic [15:0]   copr_q, copr_d;
  logic [15:0]   lopr_q, lopr_d;
  logic [15:0]   word_m;
  logic [TW-1:0] tbl_inc, link_tbl, next_tbl;

  assign tbl_inc  = table_q + 1'b1;
  assign link_tbl = cmd_q[239:240-TW];

  always_comb begin
    state_d  = state_q;
    table_d  = table_q;
    stk_d    = stk_q;
    stk_v_d  = stk_v_q;
    widx_d   = widx_q;
    rd_d     = rd_q;
    stale_d  = stale_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    cef_d    = cef_q;
    cmd_d    = cmd_q;
    copr_d   = copr_q;
    lopr_d   = lopr_q;
    next_tbl = tbl_inc;
    word_m   = VRAM_DI;
`ifdef VDP1_CMD_MASK_EN
    case (widx_q)
      4'd0:    word_m = VRAM_DI & 16'hFF3F;
      4'd1:    word_m = VRAM_DI & 16'hFFFC;
      4'd2:    word_m = VRAM_DI & 16'h9FFF;
      4'd4:    word_m = VRAM_DI & 16'hFFFC;
      4'd5:    word_m = VRAM_DI & 16'h3FFF;
      default: word_m = VRAM_DI;
    endcase
`endif

    if (START) begin
      // A read still in flight at abort will complete later; its RDY must be swallowed.
      stale_d = (rd_q | stale_q) & ~VRAM_RDY;
      rd_d    = ~stale_d;
      state_d = S_RD0;
      table_d = '0;
      widx_d  = 4'd0;
      stk_v_d = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b1;
      cef_d   = 1'b0;
      copr_d  = 16'h0000;
    end else if (stale_q) begin
      if (VRAM_RDY) stale_d = 1'b0;
    end else begin
      case (state_q)
        S_RD0, S_RDN, S_RD1: begin
          if (!rd_q) begin
            rd_d = 1'b1;
          end else if (VRAM_RDY) begin
            rd_d = 1'b0;
            cmd_d[{~widx_q, 4'hF} -: 16] = word_m;
            widx_d = widx_q + 4'd1;
            if (state_q == S_RD0) begin
              if (word_m[15])      state_d = S_FIN;
              else if (word_m[14]) state_d = S_RD1;
              else                 state_d = S_RDN;
            end else if (state_q == S_RD1) begin
              state_d = S_NEXT;
            end else if (widx_q == 4'(CMD_WORDS - 1)) begin
              state_d = S_DISP;
              valid_d = 1'b1;
            end
          end
        end
        S_DISP: begin
          if (CMD_ACK) begin
            valid_d = 1'b0;
            state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          lopr_d = copr_q;
          case (cmd_q[253:252])
            2'b00: next_tbl = tbl_inc;
            2'b01: next_tbl = link_tbl;
            2'b10: begin
              next_tbl = link_tbl;
              if (!stk_v_q) begin
                stk_v_d = 1'b1;
                stk_d   = tbl_inc;
              end
            end
            default: begin
              if (stk_v_q) begin
                next_tbl = stk_q;
                stk_v_d  = 1'b0;
              end
            end
          endcase
          table_d = next_tbl;
          copr_d  = {next_tbl, 2'b00};
          widx_d  = 4'd0;
          rd_d    = 1'b1;
          state_d = S_RD0;
        end
        S_FIN: begin
          cef_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      table_q <= '0;
      stk_q   <= '0;
      stk_v_q <= 1'b0;
      widx_q  <= 4'd0;
      rd_q    <= 1'b0;
      stale_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cef_q   <= 1'b0;
      cmd_q   <= '0;
      copr_q  <= 16'h0000;
      lopr_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      table_q <= table_d;
      stk_q   <= stk_d;
      stk_v_q <= stk_v_d;
      widx_q  <= widx_d;
      rd_q    <= rd_d;
      stale_q <= stale_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      cef_q   <= cef_d;
      cmd_q   <= cmd_d;
      copr_q  <= copr_d;
      lopr_q  <= lopr_d;
    end
  end

  assign VRAM_A    = {table_q, widx_q};
  assign VRAM_RD   = rd_q;
  assign CMD       = cmd_q;
  assign CMD_VALID = valid_q;
  assign BUSY      = busy_q;
  assign CEF       = cef_q;
  assign COPR      = copr_q;
  assign LOPR      = lopr_q;

endmodule

// File: tb/tb_vdp1_cmd_fetch.sv
// tb/tb_vdp1_cmd_fetch.sv - directed scoreboard bench for vdp1_cmd_fetch with a VRAM responder model.
module tb_vdp1_cmd_fetch;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [18:1]  VRAM_A;
  logic         VRAM_RD;
  logic [15:0]  VRAM_DI;
  logic         VRAM_RDY;
  logic [255:0] CMD;
  logic         CMD_VALID;
  logic         CMD_ACK;
  logic         BUSY;
  logic         CEF;
  logic [15:0]  COPR;
  logic [15:0]  LOPR;

  logic [15:0]  mem [0:1023];
  int           delay;
  logic [17:0]  rd_log [$];
  logic [255:0] exp_cmd [$];
  logic [15:0]  exp_copr [$];
  int           n_chk = 0;
  int           n_fail = 0;

  vdp1_cmd_fetch #(.VRAM_AW(18), .CMD_WORDS(16)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .VRAM_A(VRAM_A), .VRAM_RD(VRAM_RD), .VRAM_DI(VRAM_DI), .VRAM_RDY(VRAM_RDY),
    .CMD(CMD), .CMD_VALID(CMD_VALID), .CMD_ACK(CMD_ACK),
    .BUSY(BUSY), .CEF(CEF), .COPR(COPR), .LOPR(LOPR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [15:0] fmask(input int i, input logic [15:0] v);
`ifdef VDP1_CMD_MASK_EN
    case (i)
      0:       return v & 16'hFF3F;
      1:       return v & 16'hFFFC;
      2:       return v & 16'h9FFF;
      4:       return v & 16'hFFFC;
      5:       return v & 16'h3FFF;
      default: return v;
    endcase
`else
    if (i < 0) return 16'h0000;
    return v;
`endif
  endfunction

  function automatic logic [255:0] build_cmd(input int base);
    logic [255:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[239:0], fmask(i, mem[base + i])};
    return r;
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 16'h0125 + 16'h0A0B);
    rd_log.delete();
  endtask

  task automatic expect_cmd(input int base, input logic [15:0] copr);
    exp_cmd.push_back(build_cmd(base));
    exp_copr.push_back(copr);
  endtask

  task automatic run_list(input string tag);
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 0; c < 3000 && BUSY; c++) tick();
    chk({tag, "_done"}, BUSY, 0);
    chk({tag, "_sb_drained"}, exp_cmd.size(), 0);
  endtask

  // VRAM responder: latches a request, answers after `delay` cycles, completes every accepted read.
  initial begin : vram_model
    bit         pending = 0;
    int         cnt = 0;
    logic [9:0] paddr = '0;
    VRAM_RDY = 1'b0;
    VRAM_DI  = 16'h0000;
    forever begin
      @(negedge CLK);
      if (VRAM_RDY) begin
        VRAM_RDY = 1'b0;
        pending  = 0;
      end else if (pending) begin
        if (cnt <= 1) begin
          VRAM_RDY = 1'b1;
          VRAM_DI  = mem[paddr];
        end else begin
          cnt--;
        end
      end else if (VRAM_RD && !RST) begin
        pending = 1;
        paddr   = VRAM_A[10:1];
        cnt     = delay;
        rd_log.push_back(VRAM_A);
      end
    end
  end

  // Draw-engine side: compares each offered command against the scoreboard, then acknowledges.
  initial begin : draw_model
    logic [255:0] ec;
    logic [15:0]  ep;
    CMD_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (CMD_ACK) begin
        CMD_ACK = 1'b0;
      end else if (CMD_VALID) begin
        if (exp_cmd.size() == 0) begin
          chk("unexpected_cmd_valid", 1, 0);
        end else begin
          ec = exp_cmd.pop_front();
          ep = exp_copr.pop_front();
          chk("cmd_contents", CMD, ec);
          chk("copr_at_disp", COPR, ep);
        end
        CMD_ACK = 1'b1;
      end
    end
  end

  initial begin : stim
    int base_n;
    RST   = 1'b1;
    START = 1'b0;
    delay = 1;
    init_mem();
    repeat (3) tick();
    chk("rst_vram_a", VRAM_A, 0);
    chk("rst_vram_rd", VRAM_RD, 0);
    chk("rst_cmd", CMD, 0);
    chk("rst_cmd_valid", CMD_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cef", CEF, 0);
    chk("rst_copr", COPR, 0);
    chk("rst_lopr", LOPR, 0);
    RST = 1'b0;
    tick();

    // Single command then END.
    init_mem();
    mem[0] = 16'h0000; mem[1] = 16'h1233; mem[5] = 16'hFFFF; mem[16] = 16'h8000;
    expect_cmd(0, 16'h0000);
    run_list("single");
    chk("single_lopr", LOPR, 16'h0000);
    chk("single_copr", COPR, 16'h0004);
    chk("single_cef", CEF, 1);
    chk("single_reads", rd_log.size(), 17);
`ifdef VDP1_CMD_MASK_EN
    chk("cmdsize_slot", CMD[175:160], 16'h3FFF);
`else
    chk("cmdsize_slot", CMD[175:160], 16'hFFFF);
`endif

    // Assign jump.
    init_mem();
    mem[0] = 16'h1000; mem[1] = 16'h0040; mem[16'h100] = 16'h8000;
    expect_cmd(0, 16'h0000);
    run_list("assign");
    chk("assign_reads", rd_log.size(), 17);
    chk("assign_rd0_addr", rd_log[16], 18'h00100);
    chk("assign_copr", COPR, 16'h0040);
    chk("assign_lopr", LOPR, 16'h0000);

    // Call then return.
    init_mem();
    mem[0] = 16'h2000; mem[1] = 16'h0010; mem[16'h40] = 16'h3000; mem[16'h10] = 16'h8000;
    expect_cmd(0, 16'h0000);
    expect_cmd(16'h40, 16'h0010);
    run_list("call_ret");
    chk("call_ret_reads", rd_log.size(), 33);
    chk("call_ret_copr", COPR, 16'h0004);
    chk("call_ret_lopr", LOPR, 16'h0010);

    // Nested call with full stack acts as assign.
    init_mem();
    mem[0] = 16'h2000; mem[1] = 16'h0010; mem[16'h40] = 16'h2000; mem[16'h41] = 16'h0018;
    mem[16'h60] = 16'h8000;
    expect_cmd(0, 16'h0000);
    expect_cmd(16'h40, 16'h0010);
    run_list("nested");
    chk("nested_reads", rd_log.size(), 33);
    chk("nested_copr", COPR, 16'h0018);
    chk("nested_lopr", LOPR, 16'h0010);

    // Skip: only CTRL and LINK read, no dispatch.
    init_mem();
    mem[0] = 16'h4000; mem[16] = 16'h8000;
    run_list("skip");
    chk("skip_reads", rd_log.size(), 3);
    chk("skip_link_addr", rd_log[1], 18'h00001);
    chk("skip_next_addr", rd_log[2], 18'h00010);
    chk("skip_cef", CEF, 1);

    // Abort during word 7 with slow VRAM: the late RDY must not land in the restarted table.
    init_mem();
    delay = 3;
    mem[0] = 16'h0000; mem[7] = 16'hBEEF; mem[16] = 16'h8000;
    expect_cmd(0, 16'h0000);
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 0; c < 500 && rd_log.size() < 8; c++) tick();
    chk("abort_reached_word7", rd_log.size(), 8);
    base_n = rd_log.size();
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("abort_rd_dropped", VRAM_RD, 0);
    chk("abort_vram_a", VRAM_A, 0);
    chk("abort_no_valid", CMD_VALID, 0);
    for (int c = 0; c < 3000 && BUSY; c++) tick();
    chk("abort_done", BUSY, 0);
    chk("abort_sb_drained", exp_cmd.size(), 0);
    chk("abort_reads", rd_log.size(), base_n + 17);
    chk("abort_restart_addr", rd_log[base_n], 0);
    chk("abort_copr", COPR, 16'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
